lvds_tx: RTL and testbench

// - Transmit-side counterpart of lvds_rx: drains 32-bit I/Q words from the TX complex_fifo and serialises them MSB-first into 2-bit DDR dibits.
// - Dibits feed an SB_IO DDR output driving o_iq_tx_p/n toward the modem; the same clock is forwarded on o_iq_tx_clk.
// - Enforces modem I/Q framing: I_SYNC=2'b10 at bits [31:30], Q_SYNC=2'b01 at bits [15:14].
// - Emits idle zeros when disabled or starved.

---
 rtl/lvds_tx_fifo_if.sv | 11 +
 rtl/lvds_tx.sv | 121 ++++++++++++
 tb/tb_lvds_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_tx_fifo_if.sv
// Read-side handshake between lvds_tx and the TX complex_fifo.
// Data is presented by the FIFO the cycle after a one-cycle pull strobe.
interface lvds_tx_fifo_if;
    logic        empty;
    logic        pull;
    logic [31:0] data;

    // lvds_tx issues the pull strobes; the FIFO answers with data and its empty flag.
    modport master (input empty, input data, output pull);
    modport slave  (output empty, output data, input pull);
endinterface

// File: rtl/lvds_tx.sv
// TX serialiser: drains 32-bit I/Q words from the FIFO and emits them MSB-first as
// 2-bit DDR dibits, prefetching the next word so back-to-back words have no gap.
module lvds_tx #(
    parameter bit         FORCE_SYNC = 1'b1,
    parameter logic [1:0] IDLE_DIBIT = 2'b00
) (
    input  logic           i_ddr_clk,
    input  logic           i_rst_b,
    input  logic           i_enable,
    lvds_tx_fifo_if.master fifo,
    output logic [1:0]     o_ddr_data,
    output logic           o_tx_active,
    output logic           o_underrun,
    output logic [1:0]     o_debug_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam logic [3:0] PREFETCH_PHASE = 4'd14;
    localparam logic [3:0] LAST_PHASE     = 4'd15;

    state_t      state;
    state_t      state_next;
    logic [3:0]  phase;
    logic [31:0] sreg;
    logic [31:0] load_word;
    logic        prefetched;
    logic        starved;
    logic        load_en;
    logic        word_end;
    logic        stream_ok;

    assign stream_ok = i_enable && !fifo.empty;

    // I_SYNC sits at [31:30] and Q_SYNC at [15:14] of every modem word.
    assign load_word = FORCE_SYNC ? {2'b10, fifo.data[29:16], 2'b01, fifo.data[13:0]}
                                  : fifo.data;

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        fifo.pull  = 1'b0;
        load_en    = 1'b0;
        word_end   = 1'b0;
        case (state)
            IDLE: begin
                if (stream_ok) state_next = FETCH;
            end
            FETCH: begin
                fifo.pull  = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (phase == PREFETCH_PHASE && stream_ok) fifo.pull = 1'b1;
                if (phase == LAST_PHASE) begin
                    if (prefetched) begin
                        load_en = 1'b1;
                    end else begin
                        word_end   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // o_ddr_data holds the dibit for the current phase; loading puts dibit 0 out one edge after capture.
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sreg       <= '0;
            phase      <= '0;
            o_ddr_data <= IDLE_DIBIT;
            o_underrun <= 1'b0;
            prefetched <= 1'b0;
            starved    <= 1'b0;
        end else begin
            o_underrun <= word_end && starved;
            if (load_en) begin
                o_ddr_data <= load_word[31:30];
                sreg       <= {load_word[29:0], 2'b00};
                phase      <= '0;
            end else if (word_end) begin
                o_ddr_data <= IDLE_DIBIT;
                sreg       <= '0;
                phase      <= '0;
            end else if (state == SHIFT) begin
                o_ddr_data <= sreg[31:30];
                sreg       <= {sreg[29:0], 2'b00};
                phase      <= phase + 4'd1;
            end
            // The stream decision is latched once per word at phase 14 and acted on at phase 15.
            if (state == SHIFT && phase == PREFETCH_PHASE) begin
                prefetched <= stream_ok;
                starved    <= i_enable && fifo.empty;
            end
        end
    end

    assign o_tx_active   = (state == SHIFT);
    assign o_debug_state = state;

endmodule

// File: tb/tb_lvds_tx.sv
// Self-checking bench for lvds_tx: a queue-based FIFO model feeds the DUT and a
// monitor rebuilds transmitted words from dibits for comparison with the pushed words.
`timescale 1ns/1ps
module tb_lvds_tx;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic enable = 1'b0;
    always #HALF clk = ~clk;

    lvds_tx_fifo_if fifo ();
    lvds_tx_fifo_if fifo_raw ();
    assign fifo_raw.empty = fifo.empty;
    assign fifo_raw.data  = fifo.data;

    logic [1:0] ddr, ddr_raw, dbg, dbg_raw;
    logic       active, active_raw, und, und_raw;

    lvds_tx #(.FORCE_SYNC(1'b1), .IDLE_DIBIT(2'b00)) dut (
        .i_ddr_clk(clk), .i_rst_b(rst_b), .i_enable(enable), .fifo(fifo),
        .o_ddr_data(ddr), .o_tx_active(active), .o_underrun(und), .o_debug_state(dbg));

    lvds_tx #(.FORCE_SYNC(1'b0), .IDLE_DIBIT(2'b00)) dut_raw (
        .i_ddr_clk(clk), .i_rst_b(rst_b), .i_enable(enable), .fifo(fifo_raw),
        .o_ddr_data(ddr_raw), .o_tx_active(active_raw), .o_underrun(und_raw), .o_debug_state(dbg_raw));

    int n_cmp = 0;
    int n_err = 0;

    // FIFO model: pop on pull, data visible the cycle after the strobe.
    logic [31:0] fifo_q[$];
    logic [31:0] popped[$];
    always @(posedge clk) begin
        if (fifo.pull === 1'b1 && fifo_q.size() != 0) begin
            fifo.data <= fifo_q[0];
            popped.push_back(fifo_q[0]);
            void'(fifo_q.pop_front());
        end
        fifo.empty <= (fifo_q.size() == 0);
    end

    // Monitor, sampled on the falling edge.
    int         cyc = 0;
    int         cur_len = 0;
    int         pull_while_empty = 0;
    int         pull_cyc[$];
    int         seg_start[$];
    int         seg_len[$];
    int         und_cyc[$];
    logic [1:0] und_ddr[$];
    logic [1:0] dibits[$];
    logic [1:0] raw_dibits[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_b) begin
            if (fifo.pull === 1'b1) begin
                pull_cyc.push_back(cyc);
                if (fifo.empty !== 1'b0) pull_while_empty++;
            end
            if (active === 1'b1) begin
                if (cur_len == 0) seg_start.push_back(cyc);
                dibits.push_back(ddr);
                cur_len++;
            end else if (cur_len != 0) begin
                seg_len.push_back(cur_len);
                cur_len = 0;
            end
            if (active_raw === 1'b1) raw_dibits.push_back(ddr_raw);
            if (und === 1'b1) begin
                und_cyc.push_back(cyc);
                und_ddr.push_back(ddr);
            end
        end
    end

    // Reference model: sync fields overwritten, word sent MSB-first two bits at a time.
    function automatic logic [31:0] forced(logic [31:0] w);
        return (w & 32'h3FFF_3FFF) | 32'h8000_4000;
    endfunction

    function automatic logic [1:0] exp_dibit(logic [31:0] w, int i);
        return 2'((w >> (30 - 2 * i)) & 32'd3);
    endfunction

    function automatic logic [31:0] rx_word(int k);
        logic [31:0] w;
        w = 'x;
        for (int i = 0; i < 16; i++)
            w = {w[29:0], (16 * k + i < dibits.size()) ? dibits[16 * k + i] : 2'bxx};
        return w;
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        pull_cyc.delete(); seg_start.delete(); seg_len.delete();
        und_cyc.delete(); und_ddr.delete(); dibits.delete(); raw_dibits.delete();
        popped.delete();
        cur_len = 0;
        pull_while_empty = 0;
    endtask

    task automatic wait_active(string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(1);
            if (active === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL %s: tx_active never rose within 20 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        enable = 1'b0;
        step(3);
        n_cmp++; if (ddr !== 2'b00) begin n_err++; $display("FAIL reset_ddr: got %0d want 0", ddr); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %0b want 0", active); end
        n_cmp++; if (und !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %0b want 0", und); end
        n_cmp++; if (fifo.pull !== 1'b0) begin n_err++; $display("FAIL reset_pull: got %0b want 0", fifo.pull); end
        n_cmp++; if (dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg); end
        rst_b = 1'b1;
        step(2);
        clear_mon();
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        w = 32'h8005_4003;
        fifo_q.push_back(w);
        step(2);
        enable = 1'b1;
        step(30);
        enable = 1'b0;
        n_cmp++; if (pull_cyc.size() !== 1) begin n_err++; $display("FAIL single_pulls: got %0d want 1", pull_cyc.size()); end
        n_cmp++; if (dibits.size() !== 16) begin n_err++; $display("FAIL single_dibit_count: got %0d want 16", dibits.size()); end
        if (pull_cyc.size() != 0 && seg_start.size() != 0) begin
            n_cmp++;
            if (seg_start[0] - pull_cyc[0] !== 2) begin
                n_err++; $display("FAIL single_latency: got %0d want 2", seg_start[0] - pull_cyc[0]);
            end
        end
        for (int i = 0; i < 16 && i < dibits.size(); i++) begin
            n_cmp++;
            if (dibits[i] !== exp_dibit(forced(w), i)) begin
                n_err++; $display("FAIL single_dibit%0d: got %0d want %0d", i, dibits[i], exp_dibit(forced(w), i));
            end
        end
        n_cmp++; if (und_cyc.size() !== 1) begin n_err++; $display("FAIL single_underrun_count: got %0d want 1", und_cyc.size()); end
        if (und_cyc.size() != 0 && seg_start.size() != 0) begin
            n_cmp++;
            if (und_cyc[0] !== seg_start[0] + 16) begin
                n_err++; $display("FAIL single_underrun_time: got %0d want %0d", und_cyc[0], seg_start[0] + 16);
            end
            n_cmp++; if (und_ddr[0] !== 2'b00) begin n_err++; $display("FAIL single_idle_at_underrun: got %0d want 0", und_ddr[0]); end
        end
        n_cmp++; if (ddr !== 2'b00) begin n_err++; $display("FAIL single_idle_after: got %0d want 0", ddr); end
        clear_mon();
    endtask

    task automatic test_force_sync();
        logic [1:0] raw_or;
        fifo_q.push_back(32'h0000_0000);
        step(2);
        enable = 1'b1;
        step(30);
        enable = 1'b0;
        n_cmp++;
        if (rx_word(0) !== forced(32'h0)) begin
            n_err++; $display("FAIL force_sync_word: got %08h want %08h", rx_word(0), forced(32'h0));
        end
        raw_or = 2'b00;
        foreach (raw_dibits[i]) raw_or = raw_or | raw_dibits[i];
        n_cmp++; if (raw_dibits.size() !== 16) begin n_err++; $display("FAIL raw_dibit_count: got %0d want 16", raw_dibits.size()); end
        n_cmp++; if (raw_or !== 2'b00) begin n_err++; $display("FAIL raw_word_zero: got %0d want 0", raw_or); end
        clear_mon();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[4];
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            fifo_q.push_back(w[i]);
        end
        step(2);
        enable = 1'b1;
        step(4 * 16 + 10);
        enable = 1'b0;
        n_cmp++; if (seg_len.size() !== 1) begin n_err++; $display("FAIL b2b_segments: got %0d want 1", seg_len.size()); end
        if (seg_len.size() != 0) begin
            n_cmp++; if (seg_len[0] !== 64) begin n_err++; $display("FAIL b2b_active_len: got %0d want 64", seg_len[0]); end
        end
        n_cmp++; if (pull_cyc.size() !== 4) begin n_err++; $display("FAIL b2b_pulls: got %0d want 4", pull_cyc.size()); end
        for (int i = 0; i + 1 < pull_cyc.size(); i++) begin
            n_cmp++;
            if (pull_cyc[i + 1] - pull_cyc[i] !== 16) begin
                n_err++; $display("FAIL b2b_pull_spacing%0d: got %0d want 16", i, pull_cyc[i + 1] - pull_cyc[i]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rx_word(k) !== forced(w[k])) begin
                n_err++; $display("FAIL b2b_word%0d: got %08h want %08h", k, rx_word(k), forced(w[k]));
            end
        end
        n_cmp++; if (und_cyc.size() !== 1) begin n_err++; $display("FAIL b2b_underruns: got %0d want 1", und_cyc.size()); end
        clear_mon();
    endtask

    task automatic test_disable();
        logic [31:0] w0;
        bit ok;
        w0 = $urandom;
        fifo_q.push_back(w0);
        fifo_q.push_back($urandom);
        fifo_q.push_back($urandom);
        step(2);
        enable = 1'b1;
        wait_active("disable_start", ok);
        if (ok) begin
            step(5);
            enable = 1'b0;
            step(30);
            n_cmp++; if (pull_cyc.size() !== 1) begin n_err++; $display("FAIL disable_pulls: got %0d want 1", pull_cyc.size()); end
            n_cmp++; if (dibits.size() !== 16) begin n_err++; $display("FAIL disable_dibits: got %0d want 16", dibits.size()); end
            n_cmp++;
            if (rx_word(0) !== forced(w0)) begin
                n_err++; $display("FAIL disable_word: got %08h want %08h", rx_word(0), forced(w0));
            end
            n_cmp++; if (und_cyc.size() !== 0) begin n_err++; $display("FAIL disable_underrun: got %0d want 0", und_cyc.size()); end
            n_cmp++; if (dbg !== 2'd0) begin n_err++; $display("FAIL disable_state: got %0d want 0", dbg); end
        end
        enable = 1'b0;
        clear_mon();
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] w_next;
        bit ok;
        fifo_q.delete();
        step(2);
        fifo_q.push_back($urandom);
        w_next = $urandom;
        fifo_q.push_back(w_next);
        step(2);
        enable = 1'b1;
        wait_active("rst_mid_start", ok);
        if (ok) begin
            step(7);
            #2;
            rst_b = 1'b0;
            #1;
            n_cmp++; if (ddr !== 2'b00) begin n_err++; $display("FAIL rst_mid_ddr: got %0d want 0", ddr); end
            n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL rst_mid_active: got %0b want 0", active); end
            n_cmp++; if (fifo.pull !== 1'b0) begin n_err++; $display("FAIL rst_mid_pull: got %0b want 0", fifo.pull); end
            n_cmp++; if (dbg !== 2'd0) begin n_err++; $display("FAIL rst_mid_state: got %0d want 0", dbg); end
            enable = 1'b0;
            step(3);
            rst_b = 1'b1;
            clear_mon();
            step(5);
            n_cmp++; if (pull_cyc.size() !== 0) begin n_err++; $display("FAIL rst_mid_no_pull: got %0d want 0", pull_cyc.size()); end
            enable = 1'b1;
            step(30);
            n_cmp++; if (dibits.size() !== 16) begin n_err++; $display("FAIL rst_mid_dibits: got %0d want 16", dibits.size()); end
            n_cmp++;
            if (rx_word(0) !== forced(w_next)) begin
                n_err++; $display("FAIL rst_mid_restart_word: got %08h want %08h", rx_word(0), forced(w_next));
            end
        end
        enable = 1'b0;
        rst_b = 1'b1;
        fifo_q.delete();
        step(3);
        clear_mon();
    endtask

    task automatic test_random();
        logic [31:0] exp_words[$];
        int          burst_len[$];
        int          n;
        enable = 1'b1;
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 5);
            burst_len.push_back(n);
            for (int i = 0; i < n; i++) begin
                exp_words.push_back($urandom);
                fifo_q.push_back(exp_words[$]);
            end
            step(n * 16 + 8 + $urandom_range(0, 6));
        end
        enable = 1'b0;
        step(2);
        n_cmp++;
        if (dibits.size() !== 16 * exp_words.size()) begin
            n_err++; $display("FAIL rand_dibit_count: got %0d want %0d", dibits.size(), 16 * exp_words.size());
        end
        for (int k = 0; k < exp_words.size(); k++) begin
            n_cmp++;
            if (rx_word(k) !== forced(exp_words[k])) begin
                n_err++; $display("FAIL rand_word%0d: got %08h want %08h", k, rx_word(k), forced(exp_words[k]));
            end
        end
        n_cmp++; if (seg_len.size() !== burst_len.size()) begin n_err++; $display("FAIL rand_segments: got %0d want %0d", seg_len.size(), burst_len.size()); end
        for (int b = 0; b < burst_len.size() && b < seg_len.size(); b++) begin
            n_cmp++;
            if (seg_len[b] !== 16 * burst_len[b]) begin
                n_err++; $display("FAIL rand_seg_len%0d: got %0d want %0d", b, seg_len[b], 16 * burst_len[b]);
            end
        end
        n_cmp++; if (und_cyc.size() !== burst_len.size()) begin n_err++; $display("FAIL rand_underruns: got %0d want %0d", und_cyc.size(), burst_len.size()); end
        n_cmp++; if (pull_while_empty !== 0) begin n_err++; $display("FAIL rand_pull_while_empty: got %0d want 0", pull_while_empty); end
        n_cmp++; if (pull_cyc.size() !== exp_words.size()) begin n_err++; $display("FAIL rand_pulls: got %0d want %0d", pull_cyc.size(), exp_words.size()); end
        clear_mon();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_force_sync();
        test_back_to_back();
        test_disable();
        test_reset_mid_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
